sm83_prefetch: RTL and testbench

Parametrised instruction prefetch unit for the SM83 core, replacing the single-byte fetch with a fetch-address counter, a memory request/acknowledge handshake tolerant of wait states, and a byte queue feeding decode. It sits between the memory read port and the decode/control path. Decode consumes bytes with a valid/ready handshake, and control redirects fetch on jumps, calls, returns, RST and interrupts. The queue is flushed on every redirect.

---
 rtl/sm83_pkg.sv | 16 +
 rtl/sm83_prefetch_fifo.sv | 45 ++++
 rtl/sm83_prefetch.sv | 89 ++++++++
 tb/tb_sm83_prefetch.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sm83_pkg.sv
// Shared SM83 types: address/data words, prefetch issue states and queue entries.
package sm83_pkg;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

    typedef enum logic [1:0] {IDLE, REQ, DROP} fetch_st_t;

    // 'byte' is reserved in SystemVerilog, so the instruction byte field is 'data'.
    typedef struct packed {
        addr_t pc;
        data_t data;
    } fetch_entry_t;
endpackage

// File: rtl/sm83_prefetch_fifo.sv
// Registered FIFO with wrap-around pointers and a synchronous flush.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [PW:0]      cnt_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    // A pop in the same cycle frees the slot, so push into a full queue is legal then.
    assign do_push = push_i && ((cnt_q != FULL) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;
endmodule

// File: rtl/sm83_prefetch.sv
// Instruction prefetch: fetch-address counter, wait-state tolerant request FSM, byte queue.
module sm83_prefetch
    import sm83_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_en,
    input  logic                   redir_valid,
    input  logic [ADDR_W-1:0]      redir_pc,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_ack,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   ir_valid,
    output logic [DATA_W-1:0]      ir_data,
    output logic [ADDR_W-1:0]      ir_pc,
    input  logic                   ir_ready,
    output logic [$clog2(DEPTH):0] q_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_st_t               state_q, state_d;
    logic [ADDR_W-1:0]       fetch_pc_q, fetch_pc_d, addr_q, addr_d, base_pc;
    logic                    push, pop, space;
    logic [CW:0]             cnt_after;
    logic [ADDR_W+DATA_W-1:0] head;

    assign mem_req  = (state_q != IDLE);
    assign mem_addr = addr_q;
    assign ir_valid = (q_count != '0);
    assign push     = (state_q == REQ) && mem_ack && !redir_valid;
    assign pop      = ir_valid && ir_ready && !redir_valid;

    // Occupancy after this edge; an issue needs a free slot reserved for its data.
    assign cnt_after = redir_valid ? '0
                     : {1'b0, q_count} + (CW+1)'(push) - (CW+1)'(pop);
    assign space     = cnt_after < (CW+1)'(DEPTH);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        base_pc    = fetch_pc_q;
        if (mem_req && !mem_ack) begin
            // Outstanding request must finish at its original address; a redirect marks it dropped.
            if (redir_valid) begin
                state_d    = DROP;
                fetch_pc_d = redir_pc;
            end
        end else begin
            if (redir_valid) base_pc = redir_pc;
            else if (push)   base_pc = fetch_pc_q + ADDR_W'(1);
            fetch_pc_d = base_pc;
            addr_d     = base_pc;
            state_d    = (fetch_en && space) ? REQ : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    sync_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redir_valid),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({addr_q, mem_rdata}),
        .rdata_o (head),
        .count_o (q_count)
    );

    assign ir_pc   = head[ADDR_W+DATA_W-1:DATA_W];
    assign ir_data = head[DATA_W-1:0];
endmodule

// File: tb/tb_sm83_prefetch.sv
// Randomized and directed checks of sm83_prefetch against a transaction-level queue model.
module tb_sm83_prefetch;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1, fetch_en = 1'b0, redir_valid = 1'b0, mem_ack = 1'b0, ir_ready = 1'b0;
    logic [15:0] redir_pc = '0;
    logic [7:0]  mem_rdata = '0;
    logic        mem_req, ir_valid;
    logic [15:0] mem_addr, ir_pc;
    logic [7:0]  ir_data;
    logic [2:0]  q_count;

    always #5 clk = ~clk;

    sm83_prefetch #(.ADDR_W(16), .DATA_W(8), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc), .ir_ready(ir_ready), .q_count(q_count)
    );

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: outstanding-request record plus a queue of {pc,data}.
    typedef struct packed { logic [15:0] pc; logic [7:0] d; } ent_t;
    ent_t        q[$];
    bit          m_req = 0, m_keep = 0, checking = 0;
    logic [15:0] m_addr = '0, m_pc = '0;
    int          wait_left = 0, wait_lo = 0, wait_hi = 0;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic check_outputs();
        chk("mem_req", 32'(mem_req), 32'(m_req));
        if (m_req) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("q_count", 32'(q_count), 32'(q.size()));
        chk("ir_valid", 32'(ir_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("ir_pc", 32'(ir_pc), 32'(q[0].pc));
            chk("ir_data", 32'(ir_data), 32'(q[0].d));
        end
    endtask

    task automatic step(input bit r, input bit fe, input bit rv, input logic [15:0] rp, input bit rdy);
        bit   acked, popped, was_out, new_req;
        ent_t e;
        @(negedge clk);
        if (checking) check_outputs();
        rst = r; fetch_en = fe; redir_valid = rv; redir_pc = rp; ir_ready = rdy;
        mem_ack   = m_req && (wait_left == 0);
        mem_rdata = mem_ack ? mem_byte(m_addr) : 8'($urandom);
        acked   = mem_ack;
        was_out = m_req && !acked;
        new_req = 0;
        if (r) begin
            q.delete(); m_req = 0; m_keep = 0; m_pc = '0; m_addr = '0;
        end else begin
            popped = (q.size() != 0) && rdy;
            if (rv) q.delete();
            else begin
                if (popped) void'(q.pop_front());
                if (acked && m_keep) begin
                    e.pc = m_addr; e.d = mem_rdata;
                    q.push_back(e);
                    m_pc = m_addr + 16'd1;
                end
            end
            if (rv) m_pc = rp;
            if (m_req && !acked) begin
                if (rv) m_keep = 0;
            end else begin
                m_req = fe && (q.size() < DEPTH);
                if (m_req) begin m_addr = m_pc; m_keep = 1; new_req = 1; end
            end
        end
        if (!r && was_out) wait_left--;
        if (new_req) wait_left = $urandom_range(wait_lo, wait_hi);
        if (r) checking = 1;
    endtask

    task automatic do_reset();
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
    endtask

    initial begin
        int          nreq, first;
        bit          found;
        logic [15:0] got[3];
        int          n;

        // Reset state.
        do_reset();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_q_count", 32'(q_count), 0);
        chk("rst_ir_valid", 32'(ir_valid), 0);
        chk("rst_ir_data", 32'(ir_data), 0);
        chk("rst_ir_pc", 32'(ir_pc), 0);

        // Zero-wait fill with decode stalled, then drain in order.
        wait_lo = 0; wait_hi = 0; nreq = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, '0, 0);
            if (mem_req === 1'b1) nreq++;
        end
        chk("fill_reqs", 32'(nreq), 4);
        chk("fill_q_count", 32'(q_count), 4);
        chk("fill_req_off", 32'(mem_req), 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, '0, 1);
            chk("drain_pc", 32'(ir_pc), 32'(i));
        end

        // Three wait states: first byte visible on the fifth cycle of the request.
        do_reset();
        wait_lo = 3; wait_hi = 3; first = 0;
        step(0, 1, 0, '0, 0);
        for (int k = 1; k <= 10; k++) begin
            step(0, 1, 0, '0, 0);
            if (ir_valid === 1'b1 && first == 0) first = k;
        end
        chk("wait3_valid_cycle", 32'(first), 5);

        // Redirect to 'h0150 while the request to 'h0003 is in flight.
        do_reset();
        wait_lo = 2; wait_hi = 2; found = 0;
        step(0, 1, 0, '0, 0);
        for (int i = 0; i < 40 && !found; i++) begin
            step(0, 1, 0, '0, 0);
            if (mem_req === 1'b1 && mem_addr == 16'h0003) found = 1;
        end
        chk("redir_reach_req3", 32'(found), 1);
        step(0, 1, 1, 16'h0150, 0);
        step(0, 1, 0, '0, 0);
        chk("redir_flush", 32'(q_count), 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 1, 0, '0, 0);
            if (ir_valid === 1'b1) found = 1;
        end
        chk("redir_first_found", 32'(found), 1);
        chk("redir_first_pc", 32'(ir_pc), 32'h0150);

        // Redirect to 'hFFFE, zero wait: address wraps.
        do_reset();
        wait_lo = 0; wait_hi = 0; n = 0;
        step(0, 1, 1, 16'hFFFE, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, '0, 1);
            if (ir_valid === 1'b1 && n < 3) begin got[n] = ir_pc; n++; end
        end
        chk("wrap_n", 32'(n), 3);
        chk("wrap_pc0", 32'(got[0]), 32'hFFFE);
        chk("wrap_pc1", 32'(got[1]), 32'hFFFF);
        chk("wrap_pc2", 32'(got[2]), 32'h0000);

        // fetch_en dropped with a request outstanding: it completes, then issue stops.
        do_reset();
        wait_lo = 2; wait_hi = 2;
        step(0, 1, 0, '0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, '0, 0);
        chk("fe_low_count", 32'(q_count), 1);
        chk("fe_low_req", 32'(mem_req), 0);
        step(0, 1, 0, '0, 0);
        step(0, 1, 0, '0, 0);
        chk("fe_resume_req", 32'(mem_req), 1);
        chk("fe_resume_addr", 32'(mem_addr), 1);

        // Reset with three queued entries and a request pending.
        do_reset();
        wait_lo = 2; wait_hi = 2; found = 0;
        step(0, 1, 0, '0, 0);
        for (int i = 0; i < 40 && !found; i++) begin
            step(0, 1, 0, '0, 0);
            if (q_count == 3'd3) found = 1;
        end
        chk("rst_mid_reach", 32'(found), 1);
        chk("rst_mid_pending", 32'(mem_req), 1);
        step(1, 1, 0, '0, 0);
        step(0, 0, 0, '0, 0);
        chk("rst_mid_req", 32'(mem_req), 0);
        chk("rst_mid_count", 32'(q_count), 0);
        chk("rst_mid_addr", 32'(mem_addr), 0);

        // Random traffic.
        do_reset();
        wait_lo = 0; wait_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] rp;
            rp = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3))) : 16'($urandom);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 19) == 0, rp, $urandom_range(0, 9) < 6);
        end
        @(negedge clk);
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
